// File: rtl/instr_wr_pkg.sv
// Shared types for the instruction-memory write arbiter: sequencer states,
// AXI response codes and a small index helper.
package instr_wr_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Increment an index modulo n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: the first asserted request found
// searching upward from ptr (wrapping at N) wins.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] idx
);

  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    // An out-of-range pointer (non power-of-two N) restarts the search at 0.
    cand  = (32'(ptr) < N) ? ptr : '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
      cand = (32'(cand) == N - 1) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/instr_write_arbiter.sv
// Round-robin arbiter and single-beat AXI-lite write sequencer feeding the
// instruction-memory loader port; completion is reported to the winner.
module instr_write_arbiter
  import instr_wr_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_err,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ADDR_W-1:0]         awaddr,
  output logic                      wvalid,
  input  logic                      wready,
  output logic [DATA_W-1:0]         wdata,
  output logic [DATA_W/8-1:0]       wstrb,
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp,
  output logic                      write_address_pass,
  output logic                      write_data_pass,
  output logic                      busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     winner_q, winner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                bready_q, bready_d;
  logic [NUM_REQ-1:0]  req_done_q, req_done_d;
  logic                req_err_q, req_err_d;
  logic                pass_q, pass_d;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IdxW-1:0]     arb_idx;
  logic                aw_hs, w_hs;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign aw_hs = awvalid_q && awready;
  assign w_hs  = wvalid_q && wready;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    winner_d   = winner_q;
    addr_d     = addr_q;
    data_d     = data_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    bready_d   = bready_q;
    req_done_d = '0;
    req_err_d  = 1'b0;
    pass_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          winner_d  = arb_idx;
          addr_d    = req_addr[32'(arb_idx)*ADDR_W +: ADDR_W];
          data_d    = req_data[32'(arb_idx)*DATA_W +: DATA_W];
          rr_ptr_d  = IdxW'(wrap_inc(32'(arb_idx), NUM_REQ));
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StIssue;
        end
      end

      StIssue: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          awvalid_d = 1'b0;
        end
        if (w_hs) begin
          w_done_d = 1'b1;
          wvalid_d = 1'b0;
        end
        // Handshakes landing this cycle count towards leaving ISSUE.
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = StResp;
        end
      end

      StResp: begin
        if (bvalid) begin
          bready_d             = 1'b0;
          aw_done_d            = 1'b0;
          w_done_d             = 1'b0;
          req_done_d[winner_q] = 1'b1;
          if (bresp == RESP_OKAY) begin
            pass_d = 1'b1;
          end else begin
            req_err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end

      default: begin
        state_d   = StIdle;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      winner_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      bready_q   <= 1'b0;
      req_done_q <= '0;
      req_err_q  <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      winner_q   <= winner_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      bready_q   <= bready_d;
      req_done_q <= req_done_d;
      req_err_q  <= req_err_d;
      pass_q     <= pass_d;
    end
  end

  // Grant is only offered while idle and out of reset, so a request seen
  // during reset is never reported as accepted.
  assign req_ready          = (state_q == StIdle && !reset) ? arb_grant : '0;
  assign req_done           = req_done_q;
  assign req_err            = req_err_q;
  assign awvalid            = awvalid_q;
  assign awaddr             = addr_q;
  assign wvalid             = wvalid_q;
  assign wdata              = data_q;
  assign wstrb              = '1;
  assign bready             = bready_q;
  assign write_address_pass = pass_q;
  assign write_data_pass    = pass_q;
  assign busy               = (state_q != StIdle);

endmodule

// File: tb/tb_instr_write_arbiter.sv
// Directed bench for instr_write_arbiter: grant, round-robin order, skewed
// handshakes, error response, reset mid-transaction and throughput.
module tb_instr_write_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_done;
  logic                      req_err;
  logic                      awvalid, awready;
  logic [ADDR_W-1:0]         awaddr;
  logic                      wvalid, wready;
  logic [DATA_W-1:0]         wdata;
  logic [DATA_W/8-1:0]       wstrb;
  logic                      bvalid, bready;
  logic [1:0]                bresp;
  logic                      write_address_pass, write_data_pass, busy;

  int n_total = 0;
  int n_pass  = 0;

  instr_write_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_addr           (req_addr),
    .req_data           (req_data),
    .req_ready          (req_ready),
    .req_done           (req_done),
    .req_err            (req_err),
    .awvalid            (awvalid),
    .awready            (awready),
    .awaddr             (awaddr),
    .wvalid             (wvalid),
    .wready             (wready),
    .wdata              (wdata),
    .wstrb              (wstrb),
    .bvalid             (bvalid),
    .bready             (bready),
    .bresp              (bresp),
    .write_address_pass (write_address_pass),
    .write_data_pass    (write_data_pass),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  // Inputs are driven 1 time unit after the rising edge, outputs sampled later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Single requester 0 repeatedly; slave raises bvalid after bready has been
  // high for 'delay' cycles. Checks grant spacing and busy coverage.
  task automatic run_tp(input string tag, input int delay, input int period);
    int cnt, ng, bhigh;
    int g[3];
    bit drop, fin;
    cnt = 0; ng = 0; bhigh = 0; drop = 0; fin = 0;
    g[0] = 0; g[1] = 0; g[2] = 0;
    req_valid = 4'b0001; awready = 1'b1; wready = 1'b1; bresp = 2'b00;
    for (int c = 0; c < 60 && !fin; c++) begin
      bvalid = bready && (cnt >= delay);
      #1;
      if ((ng == 1 || ng == 2) && busy) bhigh++;
      if (req_ready[0] && ng < 3) begin
        g[ng] = c;
        ng++;
        if (ng == 3) drop = 1;
      end
      if (ng == 3 && !drop && !busy && !bready) fin = 1;
      cnt = bready ? cnt + 1 : 0;
      tick();
      if (drop) begin
        req_valid = '0;
        drop = 0;
      end
    end
    bvalid = 1'b0;
    check({tag, "_grants"}, 64'(ng), 64'd3);
    check({tag, "_period01"}, 64'(g[1] - g[0]), 64'(period));
    check({tag, "_period12"}, 64'(g[2] - g[1]), 64'(period));
    check({tag, "_busy_cycles"}, 64'(bhigh), 64'(2 * period - 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int g, passes, strobe_mism;
    bit drop, pend;
    logic [ADDR_W-1:0] exp_addr;

    reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    do_reset();

    // Reset state
    #1;
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", req_done, 4'b0000);
    check("rst_err", req_err, 1'b0);
    check("rst_pass", {write_address_pass, write_data_pass}, 2'b00);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_ready", req_ready, 4'b0000);
    tick();

    // Single request with everything tied high
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    req_valid = 4'b0010;
    req_addr[1*ADDR_W +: ADDR_W] = 32'h100;
    req_data[1*DATA_W +: DATA_W] = 32'hDEADBEEF;
    #1;
    check("t1_ready_c0", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    #1;
    check("t1_awvalid_c1", awvalid, 1'b1);
    check("t1_awaddr_c1", awaddr, 32'h100);
    check("t1_wdata_c1", wdata, 32'hDEADBEEF);
    check("t1_wstrb", wstrb, 4'hF);
    check("t1_busy_c1", busy, 1'b1);
    tick();
    #1;
    check("t1_bready_c2", bready, 1'b1);
    tick();
    #1;
    check("t1_done_c3", req_done, 4'b0010);
    check("t1_pass_c3", {write_address_pass, write_data_pass}, 2'b11);
    check("t1_err_c3", req_err, 1'b0);
    check("t1_busy_c3", busy, 1'b0);
    check("t1_rr_ptr", dut.rr_ptr_q, 2'd2);
    tick();
    #1;
    check("t1_done_c4", req_done, 4'b0000);
    check("t1_pass_c4", write_address_pass, 1'b0);
    bvalid = 1'b0;

    // All four requesting from rr_ptr 0
    do_reset();
    bvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = 32'h1000 + 32'(i) * 4;
      req_data[i*DATA_W +: DATA_W] = 32'hA000_0000 + 32'(i);
    end
    req_valid = 4'b1111;
    g = 0; passes = 0; strobe_mism = 0; drop = 0; pend = 0; exp_addr = '0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (pend) begin
        check("rr_awaddr", awaddr, exp_addr);
        pend = 0;
      end
      if (req_ready != '0 && g < 5) begin
        check("rr_grant", req_ready, 4'b0001 << exp_order[g]);
        check("rr_grant_cycle", 64'(c), 64'(3 * g));
        exp_addr = 32'h1000 + 32'(exp_order[g]) * 4;
        pend = 1;
        g++;
        if (g == 5) drop = 1;
      end
      if (write_address_pass) passes++;
      if (write_address_pass !== write_data_pass) strobe_mism++;
      tick();
      if (drop) begin
        req_valid = '0;
        drop = 0;
      end
    end
    check("rr_grants", 64'(g), 64'd5);
    check("rr_passes", 64'(passes), 64'd5);
    check("rr_strobes_coincide", 64'(strobe_mism), 64'd0);
    bvalid = 1'b0;

    // Skewed handshakes: AW in ISSUE cycle 1, W in cycle 4
    awready = 1'b0; wready = 1'b0; passes = 0;
    req_valid = 4'b1000;
    req_addr[3*ADDR_W +: ADDR_W] = 32'h300;
    req_data[3*DATA_W +: DATA_W] = 32'h1234_5678;
    tick();
    req_valid = '0;
    awready = 1'b1;
    #1;
    check("sk_c1_valids", {awvalid, wvalid}, 2'b11);
    tick();
    awready = 1'b0;
    #1;
    check("sk_c2_valids", {awvalid, wvalid}, 2'b01);
    tick();
    #1;
    check("sk_c3_valids", {awvalid, wvalid, bready}, 3'b010);
    tick();
    wready = 1'b1;
    #1;
    check("sk_c4_wvalid", wvalid, 1'b1);
    check("sk_c4_wdata", wdata, 32'h1234_5678);
    check("sk_c4_bready", bready, 1'b0);
    tick();
    wready = 1'b0;
    bvalid = 1'b1; bresp = 2'b00;
    #1;
    check("sk_c5_resp", {bready, busy, wvalid}, 3'b110);
    if (write_address_pass) passes++;
    tick();
    bvalid = 1'b0;
    #1;
    check("sk_c6_done", req_done, 4'b1000);
    if (write_address_pass) passes++;
    tick();
    #1;
    if (write_address_pass) passes++;
    check("sk_pass_count", 64'(passes), 64'd1);

    // SLVERR response
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    tick();
    #1;
    check("err_done", req_done, 4'b0001);
    check("err_err", req_err, 1'b1);
    check("err_pass", {write_address_pass, write_data_pass}, 2'b00);
    tick();
    #1;
    check("err_err_clear", req_err, 1'b0);
    bvalid = 1'b0; bresp = 2'b00;

    // Reset while in RESP with bvalid low
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    #1;
    check("rr_resp_bready", bready, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rstr_outs", {busy, bready, awvalid, wvalid, req_err, write_address_pass}, 6'b0);
    check("rstr_done", req_done, 4'b0000);
    check("rstr_awaddr", awaddr, 32'h0);
    bvalid = 1'b1;
    tick();
    #1;
    check("rstr_late_b", {req_done, write_address_pass, req_err}, 6'b0);
    bvalid = 1'b0;
    tick();

    // Throughput with responsive and slow slave
    run_tp("tp_fast", 0, 3);
    run_tp("tp_slow", 7, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_write_arbiter.md
# instr_write_arbiter

Round-robin arbiter and sequencer sharing one AXI-lite write port, the instruction-memory loader port, among NUM_REQ requesters. It accepts one single-beat write from the winning requester and drives the AW and W channels independently. It then collects the B response and reports completion back to that requester. Its write_address_pass / write_data_pass strobes feed the instruction-count monitor, so each OKAY-completed write increments the count exactly once.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  flattened data, same packing
- req_ready  out  NUM_REQ  one-hot grant/accept; combinational, high only in IDLE
- req_done  out  NUM_REQ  one-hot, one-cycle completion pulse
- req_err  out  1  one-cycle pulse with req_done when bresp != OKAY
- awvalid/awready/awaddr  out/in/out  1/1/ADDR_W  AXI-lite AW channel
- wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_W/DATA_W/8  AXI-lite W channel; wstrb all ones
- bvalid/bready/bresp  in/out/in  1/1/2  AXI-lite B channel
- write_address_pass  out  1  one-cycle pulse: AW accepted and response OKAY
- write_data_pass  out  1  one-cycle pulse: W accepted and response OKAY; always coincident with write_address_pass
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid is high, pick the winner by searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Assert req_ready[winner] and latch winner index, addr and data.
  - Set rr_ptr <= (winner+1) mod NUM_REQ. Go to ISSUE.
  - If no req_valid, stay in IDLE; rr_ptr is unchanged.
- ISSUE:
  - awvalid is high until aw_done is set; wvalid is high until w_done is set.
  - aw_done is set on awvalid&&awready; w_done is set on wvalid&&wready. The two handshakes may occur in either order or in the same cycle.
  - Go to RESP in the cycle both are done, counting a handshake that occurs in that same cycle.
- RESP:
  - bready is high.
  - On bvalid: pulse req_done[winner] next cycle.
  - bresp==2'b00: pulse both pass strobes next cycle, req_err stays low.
  - Any other bresp: pulse req_err next cycle, pass strobes stay low.
  - Go to IDLE.
- awaddr and wdata hold the latched values and stay stable while their valid is high.
- req_valid changes outside IDLE are ignored; requests are never queued internally.

## Timing
- Reset values:
  - State IDLE, rr_ptr 0, aw_done and w_done 0.
  - awvalid, wvalid, bready, req_done, req_err, pass strobes and busy all 0.
  - awaddr and wdata 0.
- awvalid, wvalid, bready and all completion strobes are registered. req_ready is combinational from the state and req_valid.
- Minimum cost is 3 cycles per write: grant (IDLE), ISSUE with both readies high, RESP with bvalid already high. The next grant can come in the cycle the completion pulse is high.
- Strobes are asserted exactly one cycle after the B handshake.
- Reset in ISSUE or RESP: the transaction is dropped, all outputs read 0 from the next edge, and no completion pulse is generated.
- A valid must not be dropped before its handshake, per AXI.

## Structure
- Shared package instr_wr_pkg: state enum (IDLE, ISSUE, RESP) and localparam RESP_OKAY = 2'b00.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs one-hot grant and binary index; purely combinational rotate-priority encode.

## Test plan
- Single request, readies and bvalid tied high:
  - req_valid=4'b0010, addr 0x100, data 0xDEADBEEF.
  - req_ready[1] in cycle 0, awaddr=0x100 and wdata=0xDEADBEEF in cycle 1.
  - req_done=4'b0010 and both pass strobes in cycle 3; rr_ptr becomes 2.
- All four requesting continuously, rr_ptr 0: grants come in order 0,1,2,3,0; exactly 5 pass pulses over 5 transactions.
- Skewed handshakes:
  - awready high at ISSUE cycle 1, wready high at cycle 4.
  - awvalid drops after cycle 1; wvalid holds until cycle 4.
  - RESP is entered at cycle 5; one pass pulse results.
- bresp=2'b10 (SLVERR): req_err and req_done pulse together, and neither pass strobe asserts.
- Reset asserted in RESP while bvalid is low: the next cycle shows state IDLE with all outputs 0, and no req_done.
- Responsive slave vs. slow slave (bvalid delayed 7 cycles): busy is high throughout; throughput is 3 cycles per write with the responsive slave, 10 with the slow one.
